// File: rtl/reg_read_addr_stage_pkg.sv
// Shared constants and state encoding for the register-read address stage.
// Optional hazard detection is enabled by defining REG2LOC_HAZARD_EN.
package reg_read_addr_stage_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_RN_LSB = 5;
    localparam int DEF_RM_LSB = 16;
    localparam int DEF_RT_LSB = 0;
    localparam int XZR_IDX    = 31;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skidState_t;

endpackage

// File: rtl/reg_read_addr_stage_skid_buffer.sv
// Two-entry valid/ready skid buffer: main entry drives the outputs, skid entry
// absorbs one transfer while downstream stalls.
module reg_read_addr_stage_skid_buffer
    import reg_read_addr_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skidState_t       state_q;
    logic [WIDTH-1:0] mainEntry_q;
    logic [WIDTH-1:0] skidEntry_q;
    logic             outValid_q;
    logic             inReady_q;
    logic             accept;
    logic             pop;

    assign accept    = in_valid && inReady_q;
    assign pop       = outValid_q && out_ready;
    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_data  = mainEntry_q;

    // Handshake flags are registered with the state so they depend only on occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= EMPTY;
            mainEntry_q <= '0;
            skidEntry_q <= '0;
            outValid_q  <= 1'b0;
            inReady_q   <= 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        mainEntry_q <= in_data;
                        outValid_q  <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        mainEntry_q <= in_data;
                    end else if (accept) begin
                        skidEntry_q <= in_data;
                        inReady_q   <= 1'b0;
                        state_q     <= FULL;
                    end else if (pop) begin
                        outValid_q  <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        mainEntry_q <= skidEntry_q;
                        inReady_q   <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_read_addr_stage.sv
// Register-read address stage: picks Rn and Rm/Rt from the instruction and buffers them
// with the pipeline register. Define REG2LOC_HAZARD_EN for load-use stall detection.
module reg_read_addr_stage
    import reg_read_addr_stage_pkg::*;
#(
    parameter int PR_W   = 500,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int RN_LSB = DEF_RN_LSB,
    parameter int RM_LSB = DEF_RM_LSB,
    parameter int RT_LSB = DEF_RT_LSB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PR_W-1:0]   in_pr,
    input  logic              reg2loc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [PR_W-1:0]   out_pr,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              ex_mem_rd,
    output logic [15:0]       stall_cnt
);

    localparam int DW = PR_W + 2 * ADDR_W;

    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic              hazard;
    logic              bufInReady;
    logic [DW-1:0]     bufOut;

    assign addr1 = in_pr[RN_LSB +: ADDR_W];
    assign addr2 = reg2loc ? in_pr[RT_LSB +: ADDR_W] : in_pr[RM_LSB +: ADDR_W];

`ifdef REG2LOC_HAZARD_EN
    logic [15:0] stallCnt_q;
    logic [15:0] stallCnt_d;

    // Writes to XZR never create a dependency.
    assign hazard = in_valid && ex_mem_rd && (ex_rd != ADDR_W'(XZR_IDX)) &&
                    ((ex_rd == addr1) || (ex_rd == addr2));

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (hazard && (stallCnt_q != 16'hFFFF)) begin
            stallCnt_d = stallCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
`else
    logic unusedHazardInputs;

    assign hazard             = 1'b0;
    assign stall_cnt          = '0;
    assign unusedHazardInputs = ^{ex_rd, ex_mem_rd};
`endif

    assign in_ready = bufInReady && !hazard;

    reg_read_addr_stage_skid_buffer #(
        .WIDTH(DW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid && !hazard),
        .in_ready (bufInReady),
        .in_data  ({addr1, addr2, in_pr}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (bufOut)
    );

    assign {rd_addr1, rd_addr2, out_pr} = bufOut;

endmodule
